// File: rtl/exe_if.sv
// exe stage bus: ID/EXE register outputs in, EXE/MEM bundle and stall out.
// The master drives the exi_* side; the execute stage is the slave.
interface exe_if;
    logic [15:0] exi_instr;
    logic [15:0] exi_pc;
    logic [7:0]  exi_alu_opcode;
    logic [15:0] exi_op1;
    logic [15:0] exi_op2;
    logic [3:0]  exi_wreg_addr;
    logic [15:0] exi_write_to_mem_data;
    logic [1:0]  exi_rwe;
    logic        exi_branch;

    logic [15:0] exo_instr;
    logic [15:0] exo_pc;
    logic [15:0] exo_result;
    logic [3:0]  exo_wreg_addr;
    logic [15:0] exo_write_to_mem_data;
    logic [1:0]  exo_rwe;
    logic        exo_branch;
    logic        exo_t;
    logic        exo_stall;

    modport master (
        output exi_instr, exi_pc, exi_alu_opcode, exi_op1, exi_op2,
        output exi_wreg_addr, exi_write_to_mem_data, exi_rwe, exi_branch,
        input  exo_instr, exo_pc, exo_result, exo_wreg_addr,
        input  exo_write_to_mem_data, exo_rwe, exo_branch, exo_t, exo_stall
    );

    modport slave (
        input  exi_instr, exi_pc, exi_alu_opcode, exi_op1, exi_op2,
        input  exi_wreg_addr, exi_write_to_mem_data, exi_rwe, exi_branch,
        output exo_instr, exo_pc, exo_result, exo_wreg_addr,
        output exo_write_to_mem_data, exo_rwe, exo_branch, exo_t, exo_stall
    );
endinterface

// File: rtl/exe.sv
// Execute stage: single-cycle ALU, 16-step MUL/DIVU engine, T flag owner.
// The engine stalls the front of the pipe while it iterates.
module exe (
    input logic exi_clk,
    input logic exi_rst,
    exe_if.slave bus
);
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_SLL  = 8'h06;
    localparam logic [7:0] OP_SRL  = 8'h07;
    localparam logic [7:0] OP_SRA  = 8'h08;
    localparam logic [7:0] OP_CMP  = 8'h09;
    localparam logic [7:0] OP_SLT  = 8'h0A;
    localparam logic [7:0] OP_SLTU = 8'h0B;
    localparam logic [7:0] OP_MOVE = 8'h0C;
    localparam logic [7:0] OP_MUL  = 8'h0D;
    localparam logic [7:0] OP_DIVU = 8'h0E;
    localparam logic [7:0] OP_MFT  = 8'h0F;

    localparam logic [3:0] REG_INVALID = 4'hF;
    localparam logic [1:0] RWE_IDLE    = 2'b00;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        t;
    logic [15:0] l_instr, l_pc, l_mdata;
    logic [3:0]  l_wreg;
    logic [1:0]  l_rwe;
    logic        l_div;
    logic [15:0] acc, a, b, rem;

    logic        is_multi;
    logic [15:0] alu_res;
    logic        t_we, t_nxt;
    logic [16:0] rem_sh;
    logic        ge;
    logic [15:0] rem_sub;

    assign is_multi = (state == IDLE) &&
                      ((bus.exi_alu_opcode == OP_MUL) ||
                       (bus.exi_alu_opcode == OP_DIVU));

    // Restoring division: a doubles as dividend shifter and quotient.
    assign rem_sh  = {rem, a[15]};
    assign ge      = rem_sh >= {1'b0, b};
    assign rem_sub = rem_sh[15:0] - b;

    always_comb begin
        alu_res = '0;
        t_we    = 1'b0;
        t_nxt   = t;
        case (bus.exi_alu_opcode)
            OP_NOP:  alu_res = '0;
            OP_ADD:  alu_res = bus.exi_op1 + bus.exi_op2;
            OP_SUB:  alu_res = bus.exi_op1 - bus.exi_op2;
            OP_AND:  alu_res = bus.exi_op1 & bus.exi_op2;
            OP_OR:   alu_res = bus.exi_op1 | bus.exi_op2;
            OP_XOR:  alu_res = bus.exi_op1 ^ bus.exi_op2;
            OP_SLL:  alu_res = bus.exi_op1 << bus.exi_op2[3:0];
            OP_SRL:  alu_res = bus.exi_op1 >> bus.exi_op2[3:0];
            OP_SRA:  alu_res = $unsigned($signed(bus.exi_op1) >>> bus.exi_op2[3:0]);
            OP_CMP: begin
                t_we    = 1'b1;
                t_nxt   = bus.exi_op1 != bus.exi_op2;
                alu_res = {15'b0, t_nxt};
            end
            OP_SLT: begin
                t_we    = 1'b1;
                t_nxt   = $signed(bus.exi_op1) < $signed(bus.exi_op2);
                alu_res = {15'b0, t_nxt};
            end
            OP_SLTU: begin
                t_we    = 1'b1;
                t_nxt   = bus.exi_op1 < bus.exi_op2;
                alu_res = {15'b0, t_nxt};
            end
            OP_MOVE: alu_res = bus.exi_op2;
            OP_MFT:  alu_res = {15'b0, t};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge exi_clk) begin
        if (exi_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            t       <= 1'b0;
            l_instr <= '0;
            l_pc    <= '0;
            l_mdata <= '0;
            l_wreg  <= '0;
            l_rwe   <= '0;
            l_div   <= 1'b0;
            acc     <= '0;
            a       <= '0;
            b       <= '0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_multi) begin
                        l_instr <= bus.exi_instr;
                        l_pc    <= bus.exi_pc;
                        l_mdata <= bus.exi_write_to_mem_data;
                        l_wreg  <= bus.exi_wreg_addr;
                        l_rwe   <= bus.exi_rwe;
                        l_div   <= bus.exi_alu_opcode == OP_DIVU;
                        a       <= bus.exi_op1;
                        b       <= bus.exi_op2;
                        acc     <= '0;
                        rem     <= '0;
                        cnt     <= '0;
                        state   <= BUSY;
                    end else if (t_we) begin
                        t <= t_nxt;
                    end
                end
                BUSY: begin
                    if (l_div) begin
                        a   <= {a[14:0], ge};
                        rem <= ge ? rem_sub : rem_sh[15:0];
                    end else begin
                        if (b[0]) acc <= acc + a;
                        a <= a << 1;
                        b <= b >> 1;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.exo_instr             = bus.exi_instr;
        bus.exo_pc                = bus.exi_pc;
        bus.exo_result            = alu_res;
        bus.exo_wreg_addr         = bus.exi_wreg_addr;
        bus.exo_write_to_mem_data = bus.exi_write_to_mem_data;
        bus.exo_rwe               = bus.exi_rwe;
        bus.exo_branch            = bus.exi_branch;
        bus.exo_stall             = 1'b0;
        bus.exo_t                 = t;
        case (state)
            IDLE: begin
                if (is_multi) begin
                    bus.exo_stall     = 1'b1;
                    bus.exo_result    = '0;
                    bus.exo_wreg_addr = REG_INVALID;
                    bus.exo_rwe       = RWE_IDLE;
                    bus.exo_branch    = 1'b0;
                end
            end
            DONE: begin
                bus.exo_instr             = l_instr;
                bus.exo_pc                = l_pc;
                bus.exo_result            = l_div ? a : acc;
                bus.exo_wreg_addr         = l_wreg;
                bus.exo_write_to_mem_data = l_mdata;
                bus.exo_rwe               = l_rwe;
                bus.exo_branch            = 1'b0;
            end
            default: begin
                bus.exo_instr             = l_instr;
                bus.exo_pc                = l_pc;
                bus.exo_write_to_mem_data = l_mdata;
                bus.exo_stall             = 1'b1;
                bus.exo_result            = '0;
                bus.exo_wreg_addr         = REG_INVALID;
                bus.exo_rwe               = RWE_IDLE;
                bus.exo_branch            = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_exe.sv
// Bench for exe: directed plan steps plus random ops against an
// arithmetic reference model of the ALU, engine and T flag.
module tb_exe;
    localparam logic [3:0] REG_INV  = 4'hF;
    localparam logic [1:0] RWE_IDLE = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic model_t = 1'b0;

    exe_if bus ();

    exe dut (
        .exi_clk (clk),
        .exi_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [7:0] op,
        input logic [15:0] x, input logic [15:0] y, input logic tf);
        shortint sx, sy;
        int sh;
        sx = x;
        sy = y;
        sh = int'(y % 16);
        case (op)
            8'h01: return x + y;
            8'h02: return x - y;
            8'h03: return x & y;
            8'h04: return x | y;
            8'h05: return x ^ y;
            8'h06: return x << sh;
            8'h07: return x >> sh;
            8'h08: return 16'(sx >>> sh);
            8'h09: return (x != y) ? 16'd1 : 16'd0;
            8'h0A: return (sx < sy) ? 16'd1 : 16'd0;
            8'h0B: return (x < y) ? 16'd1 : 16'd0;
            8'h0C: return y;
            8'h0F: return {15'b0, tf};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] ref_multi(input logic [7:0] op,
        input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = 32'(x) * 32'(y);
        if (op == 8'h0D) return p[15:0];
        return (y == 16'h0) ? 16'hFFFF : x / y;
    endfunction

    task automatic drive(input logic [7:0] op, input logic [15:0] x,
        input logic [15:0] y, input logic [3:0] wr, input logic [15:0] ins,
        input logic [15:0] pc, input logic [1:0] rwe,
        input logic [15:0] md, input logic br);
        bus.exi_alu_opcode        = op;
        bus.exi_op1               = x;
        bus.exi_op2               = y;
        bus.exi_wreg_addr         = wr;
        bus.exi_instr             = ins;
        bus.exi_pc                = pc;
        bus.exi_rwe               = rwe;
        bus.exi_write_to_mem_data = md;
        bus.exi_branch            = br;
    endtask

    task automatic garbage();
        drive(8'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
              16'($urandom), 16'($urandom), 2'($urandom), 16'($urandom),
              1'($urandom));
    endtask

    task automatic single(input string tag, input logic [7:0] op,
        input logic [15:0] x, input logic [15:0] y, input logic [3:0] wr);
        logic [15:0] ins, pc, md;
        logic [1:0] rwe;
        logic br;
        ins = 16'($urandom);
        pc  = 16'($urandom);
        md  = 16'($urandom);
        rwe = 2'($urandom);
        br  = 1'($urandom);
        drive(op, x, y, wr, ins, pc, rwe, md, br);
        @(negedge clk);
        chk({tag, ".result"}, 32'(bus.exo_result), 32'(ref_alu(op, x, y, model_t)));
        chk({tag, ".stall"}, 32'(bus.exo_stall), 32'd0);
        chk({tag, ".t"}, 32'(bus.exo_t), 32'(model_t));
        chk({tag, ".ctl"},
            {bus.exo_wreg_addr, bus.exo_rwe, bus.exo_branch},
            {wr, rwe, br});
        chk({tag, ".pass"}, {bus.exo_instr, bus.exo_pc ^ bus.exo_write_to_mem_data},
            {ins, pc ^ md});
        @(posedge clk);
        if (op == 8'h09 || op == 8'h0A || op == 8'h0B)
            model_t = ref_alu(op, x, y, model_t) != 16'h0;
        #1;
    endtask

    task automatic multi(input string tag, input logic [7:0] op,
        input logic [15:0] x, input logic [15:0] y, input logic [3:0] wr);
        logic [15:0] ins, pc, md;
        logic [1:0] rwe;
        int n;
        bit done;
        ins = 16'($urandom);
        pc  = 16'($urandom);
        md  = 16'($urandom);
        rwe = 2'($urandom);
        n = 0;
        done = 0;
        drive(op, x, y, wr, ins, pc, rwe, md, 1'b0);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.exo_stall) begin
                n++;
                chk({tag, ".bubble"},
                    {bus.exo_result, bus.exo_wreg_addr, bus.exo_rwe, bus.exo_branch},
                    {16'h0, REG_INV, RWE_IDLE, 1'b0});
            end else begin
                done = 1;
                chk({tag, ".stall_cycles"}, 32'(n), 32'd17);
                chk({tag, ".result"}, 32'(bus.exo_result), 32'(ref_multi(op, x, y)));
                chk({tag, ".ctl"}, {bus.exo_wreg_addr, bus.exo_rwe, bus.exo_branch},
                    {wr, rwe, 1'b0});
                chk({tag, ".latched"}, {bus.exo_instr, bus.exo_pc},
                    {ins, pc});
                chk({tag, ".mdata"}, 32'(bus.exo_write_to_mem_data), 32'(md));
                chk({tag, ".t"}, 32'(bus.exo_t), 32'(model_t));
            end
            @(posedge clk);
            #1;
            garbage();
        end
        if (!done) chk({tag, ".timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        logic [7:0] op;
        garbage();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_t = 1'b0;
        single("reset_nop", 8'h00, 16'h1234, 16'h5678, REG_INV);

        single("add_wrap", 8'h01, 16'hFFFF, 16'h0002, 4'd1);
        single("sra", 8'h08, 16'h8000, 16'h0004, 4'd2);
        single("srl", 8'h07, 16'h8000, 16'h0004, 4'd3);
        single("slt", 8'h0A, 16'hFFFF, 16'h0001, 4'd4);
        single("sltu", 8'h0B, 16'hFFFF, 16'h0001, 4'd5);
        single("mft0", 8'h0F, 16'h0, 16'h0, 4'd6);
        single("cmp", 8'h09, 16'h0001, 16'h0002, 4'd7);

        multi("mul_1234", 8'h0D, 16'h1234, 16'h0010, 4'd3);
        multi("mul_ffff", 8'h0D, 16'hFFFF, 16'hFFFF, 4'd4);
        multi("divu_64_7", 8'h0E, 16'h0064, 16'h0007, 4'd5);
        multi("divu_by0", 8'h0E, 16'h1234, 16'h0000, 4'd6);
        single("mft1", 8'h0F, 16'h0, 16'h0, 4'd1);

        drive(8'h0E, 16'hABCD, 16'h0003, 4'd2, 16'h1, 16'h2, 2'b11, 16'h3, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("abort.stall", {bus.exo_stall, bus.exo_wreg_addr}, {1'b1, REG_INV});
            if (k == 8) rst = 1'b1;
            @(posedge clk);
            #1;
            garbage();
        end
        rst = 1'b0;
        model_t = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(8'h00, 16'h0, 16'h0, REG_INV, 16'h0, 16'h0, RWE_IDLE, 16'h0, 1'b0);
            @(negedge clk);
            chk("abort.after", {bus.exo_stall, bus.exo_wreg_addr, bus.exo_rwe, bus.exo_t},
                {1'b0, REG_INV, RWE_IDLE, 1'b0});
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 80; k++) begin
            op = 8'($urandom_range(0, 15));
            if (op == 8'h0D || op == 8'h0E) op = 8'($urandom_range(16, 255));
            single("rnd", op, 16'($urandom), 16'($urandom), 4'($urandom));
        end
        for (int k = 0; k < 6; k++) begin
            op = (k % 2 == 0) ? 8'h0D : 8'h0E;
            multi("rnd_multi", op, 16'($urandom), 16'($urandom_range(0, 300)),
                  4'($urandom));
            single("rnd_after", 8'h0F, 16'h0, 16'h0, 4'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
